// File: rtl/mem_arbiter.sv
// Arbiter that shares one single-port RAM with registered read data between
// two masters. Grants use a bounded-burst round-robin, and read data is steered back by tag.
module mem_arbiter #(
    parameter int WIDTH     = 16,
    parameter int ADR_BITS  = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_req,
    input  logic                a_we,
    input  logic [ADR_BITS-1:0] a_adr,
    input  logic [WIDTH-1:0]    a_wdata,
    input  logic                b_req,
    input  logic                b_we,
    input  logic [ADR_BITS-1:0] b_adr,
    input  logic [WIDTH-1:0]    b_wdata,
    output logic                a_gnt,
    output logic                b_gnt,
    output logic                a_rvalid,
    output logic                b_rvalid,
    output logic [WIDTH-1:0]    a_rdata,
    output logic [WIDTH-1:0]    b_rdata,
    output logic                mem_en,
    output logic                mem_write,
    output logic [ADR_BITS-1:0] mem_adr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata
);

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_A    = 2'd1,
        SRC_B    = 2'd2
    } src_e;

    src_e             owner;
    src_e             last;
    src_e             rd_tag;
    src_e             g;
    src_e             other;
    logic [CNT_W-1:0] cnt;
    logic             own_req;
    logic             oth_req;

    // Requests seen from the current owner's point of view.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        own_req = 1'b0;
        oth_req = 1'b0;
        other   = SRC_NONE;
        case (owner)
            SRC_A: begin
                own_req = a_req;
                oth_req = b_req;
                other   = SRC_B;
            end
            SRC_B: begin
                own_req = b_req;
                oth_req = a_req;
                other   = SRC_A;
            end
            default: ;
        endcase
    end

    // The owner keeps the RAM until its burst is used up and the other master is waiting.
    always_comb begin
        g = SRC_NONE;
        if (!rst_n)
            g = SRC_NONE;
        else if (owner != SRC_NONE && own_req && (!oth_req || cnt < CNT_MAX))
            g = owner;
        else if (owner != SRC_NONE && oth_req)
            g = other;
        else if (a_req && b_req)
            g = (last == SRC_A) ? SRC_B : SRC_A;
        else if (a_req)
            g = SRC_A;
        else if (b_req)
            g = SRC_B;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_write = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        case (g)
            SRC_A: begin
                mem_en    = 1'b1;
                mem_write = a_we;
                mem_adr   = a_adr;
                mem_wdata = a_wdata;
            end
            SRC_B: begin
                mem_en    = 1'b1;
                mem_write = b_we;
                mem_adr   = b_adr;
                mem_wdata = b_wdata;
            end
            default: ;
        endcase
    end

    assign a_gnt    = (g == SRC_A);
    assign b_gnt    = (g == SRC_B);
    assign a_rvalid = (rd_tag == SRC_A);
    assign b_rvalid = (rd_tag == SRC_B);
    assign a_rdata  = mem_rdata;
    assign b_rdata  = mem_rdata;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner  <= SRC_NONE;
            last   <= SRC_B;
            cnt    <= '0;
            rd_tag <= SRC_NONE;
        end else begin
            owner <= g;
            if (g == SRC_NONE)
                cnt <= '0;
            else if (g == owner) begin
                if (cnt != CNT_MAX)
                    cnt <= cnt + CNT_W'(1);
            end else
                cnt <= CNT_W'(1);
            if (g != SRC_NONE)
                last <= g;
            // The tag follows the read so the data returning next cycle reaches its requester.
            rd_tag <= (g != SRC_NONE && !mem_write) ? g : SRC_NONE;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port, clocked block RAM (one access per cycle, read data registered one cycle after the address) between the processor (port A) and a secondary master such as a loader or display engine (port B). It muxes address, write data and write enable onto the RAM, issues grants with a bounded-burst round-robin policy, and routes returning read data back to the requester that issued the read. It sits between the masters and the RAM instance at the top level.

## Interface
- WIDTH, 16, data word width
- ADR_BITS, 16, address width
- MAX_BURST, 4, max consecutive grants to one requester while the other waits (≥1)

- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- a_req, b_req  input  1  access request; held with command stable until granted
- a_we, b_we  input  1  1 = write, 0 = read
- a_adr, b_adr  input  ADR_BITS  access address
- a_wdata, b_wdata  input  WIDTH  write data
- a_gnt, b_gnt  output  1  combinational grant; access is performed at this clock edge
- a_rvalid, b_rvalid  output  1  registered; read data valid for this requester
- a_rdata, b_rdata  output  WIDTH  read data (mem_rdata passthrough), meaningful only with rvalid
- mem_en  output  1  RAM enable
- mem_write  output  1  RAM write enable
- mem_adr  output  ADR_BITS  RAM address
- mem_wdata  output  WIDTH  RAM write data
- mem_rdata  input  WIDTH  RAM registered read data

## Operation
- State: owner ∈ {NONE, A, B}; last (last granted, reset = B so A wins first tie); cnt (consecutive grants to owner, saturates at MAX_BURST); rd_tag ∈ {none, A, B} (pending read).
- Grant decision per cycle, g:
  - owner ≠ NONE, owner req, and (other not requesting or cnt < MAX_BURST): g = owner.
  - else if other req: g = other; if owner = NONE and both request, g = not last.
  - else if only one req: g = that one; none requesting: g = none.
- At edge: owner ← g (NONE if none); cnt ← cnt+1 (sat.) if g = previous owner, else 1; 0 if none; last ← g if g ≠ none.
- RAM drive: mem_en = (g ≠ none); mem_write = granted we; mem_adr/mem_wdata = granted requester's; all 0 when idle.
- Read return: rd_tag ← g if granted access is a read, else none. x_rvalid = (rd_tag = x). Both rdata outputs = mem_rdata.
- Writes produce no rvalid. At most one of a_gnt/b_gnt, one of a_rvalid/b_rvalid high.
- Requester dropping req without grant: allowed, no access issued.

## Timing
- Grant latency 0 cycles: gnt combinational from req and state in the request cycle.
- Read latency: rvalid high exactly the cycle after the granting edge, for one cycle.
- Back-to-back accesses every cycle, including owner switch, with no bubble; read on A then read on B gives a_rvalid then b_rvalid in consecutive cycles.
- Reset (rst_n low, async): owner NONE, last B, cnt 0, rd_tag none; a/b_rvalid 0 immediately; with req low, all gnt/mem_* outputs 0. In-flight read result discarded. Grants not issued while rst_n low.
- MAX_BURST = 1: strict alternation under contention.
- Uncontended requester keeps grant indefinitely (cnt saturates, no forced yield).

## Test plan
- Reset/idle: rst_n low with reqs low → all outputs 0; release, no req → mem_en 0, mem_adr 0, no gnt for 10 cycles.
- Single read: RAM[0x0010]=0x1234, A req read 0x0010 → a_gnt same cycle, mem_adr 0x0010; next cycle a_rvalid=1, a_rdata=0x1234, b_rvalid=0.
- Write/readback: B writes 0xBEEF to 0x0100 (b_gnt, mem_write=1), then reads 0x0100 → b_rvalid next cycle with 0xBEEF.
- Contention, MAX_BURST=4: both hold req from reset → grants A,A,A,A,B,B,B,B,A…; rvalid tags follow each read's owner, no bubbles.
- Late contender: A requesting continuously, B raises req after A's 2nd grant → B granted after A's 4th grant; B drops req → A resumes next cycle.
- Reset mid-burst: assert rst_n during an A read grant → a_rvalid 0 immediately, no rvalid after release; both request after release → A granted first.
